// File: rtl/aes128_req_arbiter.sv
// aes128_req_arbiter: two-requester round-robin front-end for one aes128_top core.
// Latches the granted request's plaintext and key, runs the core by releasing
// its synchronous reset, captures ciphertext (and optionally the decrypted
// round-trip result) and returns it over a valid/ready response port.
// Optional feature macro: AES_ARB_ROUNDTRIP_CHECK_EN
//   defined   -> RUN ends at DEC_DONE_STATE, resp_ok is a real 128-bit compare
//   undefined -> RUN ends at ENC_DONE_STATE, resp_ok reads 1 with every response
module aes128_req_arbiter #(
  parameter int unsigned ENC_DONE_STATE = 11,
  parameter int unsigned DEC_DONE_STATE = 22,
  parameter bit          RR_INIT        = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_in,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_in,
  input  logic [127:0] req1_key,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [127:0] resp_ct,
  output logic         resp_ok,
  output logic         core_rst,
  output logic [127:0] core_in,
  output logic [127:0] core_key,
  input  logic [5:0]   core_state,
  input  logic [127:0] core_out
);

`ifdef AES_ARB_ROUNDTRIP_CHECK_EN
  localparam bit ROUNDTRIP = 1'b1;
`else
  localparam bit ROUNDTRIP = 1'b0;
`endif

  localparam logic [5:0] ENC_ST  = 6'(ENC_DONE_STATE);
  localparam logic [5:0] DONE_ST = ROUNDTRIP ? 6'(DEC_DONE_STATE) : 6'(ENC_DONE_STATE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  logic   ptr;
  logic   grant;
  logic   accept;

  // Grant selection: pointer owner first, otherwise the other valid requester.
  always_comb begin
    grant = ptr;
    if (ptr ? req1_valid : req0_valid) begin
      grant = ptr;
    end else if (ptr ? req0_valid : req1_valid) begin
      grant = ~ptr;
    end
    req0_ready = (state == IDLE) && !grant;
    req1_ready = (state == IDLE) &&  grant;
    accept     = (state == IDLE) && (grant ? req1_valid : req0_valid);
  end

  // Core is held in reset everywhere except RUN, so it parks at state 0.
  always_comb begin
    core_rst = (state != RUN);
  end

  // Main sequencer: accept, launch, run the core, hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= RR_INIT;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_ok    <= 1'b0;
      resp_ct    <= '0;
      core_in    <= '0;
      core_key   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            core_in  <= grant ? req1_in  : req0_in;
            core_key <= grant ? req1_key : req0_key;
            resp_id  <= grant;
            ptr      <= ~grant;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= RUN;
        end
        RUN: begin
          if (core_state == ENC_ST) begin
            resp_ct <= core_out;
          end
          // Without the round-trip check DONE_ST equals ENC_ST, so the
          // ciphertext capture and the move to RESP share one edge.
          if (core_state == DONE_ST) begin
`ifdef AES_ARB_ROUNDTRIP_CHECK_EN
            resp_ok <= (core_out == core_in);
`else
            resp_ok <= 1'b1;
`endif
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
`ifndef AES_ARB_ROUNDTRIP_CHECK_EN
            resp_ok    <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_req_arbiter.sv
// Testbench for aes128_req_arbiter with a behavioural stand-in for aes128_top:
// the stand-in counts state 1,2,... while out of reset, presents the known
// ciphertext at state 11 and the decrypted plaintext at state 22.
module tb_aes128_req_arbiter;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;

`ifdef AES_ARB_ROUNDTRIP_CHECK_EN
  localparam int EXP_EDGES = 23;   // 24-cycle accept-to-response
  localparam bit RT        = 1'b1;
`else
  localparam int EXP_EDGES = 12;   // 13-cycle accept-to-response
  localparam bit RT        = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_in = '0, req0_key = '0, req1_in = '0, req1_key = '0;
  logic         resp_valid, resp_id, resp_ok;
  logic         resp_ready = 1'b0;
  logic [127:0] resp_ct;
  logic         core_rst;
  logic [127:0] core_in, core_key;
  logic [5:0]   core_state;
  logic [127:0] core_out;

  always #5 clk = ~clk;

  aes128_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in), .req1_key(req1_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_ct(resp_ct), .resp_ok(resp_ok),
    .core_rst(core_rst), .core_in(core_in), .core_key(core_key),
    .core_state(core_state), .core_out(core_out)
  );

  // ---------------- behavioural core stand-in ----------------
  logic [5:0] cnt = '0;
  logic       corrupt = 1'b0;

  function automatic logic [127:0] ct_fn(input logic [127:0] pt, input logic [127:0] k);
    if (pt == P0 && k == K0) return C0;
    if (pt == P1 && k == K1) return C1;
    return pt ^ k ^ 128'h5a5a5a5a_a5a5a5a5_5a5a5a5a_a5a5a5a5;
  endfunction

  always @(posedge clk) cnt <= core_rst ? 6'd0 : cnt + 6'd1;

  always_comb begin
    core_state = core_rst ? 6'd0 : cnt + 6'd1;
    core_out   = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    if (core_state == 6'd11)      core_out = ct_fn(core_in, core_key);
    else if (core_state == 6'd22) core_out = core_in ^ {127'd0, corrupt};
  end

  // ---------------- scoreboard / counters ----------------
  typedef struct {
    logic         id;
    logic [127:0] ct;
    logic         ok;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Tracks "not IDLE" from accept to response handshake; ready there is illegal.
  logic busy = 1'b0;
  int   ready_viol = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) busy <= 1'b1;
    else if (resp_valid && resp_ready) busy <= 1'b0;
  end
  always @(negedge clk) if (busy && (req0_ready || req1_ready)) ready_viol++;

  // Drive one request and wait for its response; returns observations only.
  task automatic do_txn(input bit id, input logic [127:0] pt, input logic [127:0] k,
                        output bit accepted, output int lat,
                        output logic [127:0] lin, output logic [127:0] lkey);
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_in = pt; req1_key = k; end
    else    begin req0_valid = 1'b1; req0_in = pt; req0_key = k; end
    accepted = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin accepted = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    lin  = core_in;
    lkey = core_key;
    lat  = 0;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0; corrupt = 1'b0;
    #12;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL rst_resp_id got %b exp 0", resp_id); end
    checks++; if (resp_ok !== 1'b0) begin errors++; $display("FAIL rst_resp_ok got %b exp 0", resp_ok); end
    checks++; if (resp_ct !== '0) begin errors++; $display("FAIL rst_resp_ct got %h exp 0", resp_ct); end
    checks++; if (core_in !== '0 || core_key !== '0) begin errors++; $display("FAIL rst_core_opnd got %h/%h exp 0/0", core_in, core_key); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst got %b exp 1", core_rst); end
    req1_valid = 1'b1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL rst_grant_req1 got %b exp 01", {req0_ready, req1_ready}); end
    req0_valid = 1'b1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rst_grant_ptr0 got %b exp 10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single(input bit id, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] ct);
    bit acc; int lat; logic [127:0] lin, lkey; exp_t e;
    resp_ready = 1'b1;
    sb.push_back('{id: id, ct: ct, ok: 1'b1});
    do_txn(id, pt, k, acc, lat, lin, lkey);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single%0d_accept got %b exp 1", id, acc); end
    checks++; if (lin !== pt || lkey !== k) begin errors++; $display("FAIL single%0d_latch got %h/%h exp %h/%h", id, lin, lkey, pt, k); end
    checks++; if (lat !== EXP_EDGES) begin errors++; $display("FAIL single%0d_latency got %0d exp %0d", id, lat, EXP_EDGES); end
    e = sb.pop_front();
    checks++; if (resp_id !== e.id) begin errors++; $display("FAIL single%0d_id got %b exp %b", id, resp_id, e.id); end
    checks++; if (resp_ct !== e.ct) begin errors++; $display("FAIL single%0d_ct got %h exp %h", id, resp_ct, e.ct); end
    checks++; if (resp_ok !== e.ok) begin errors++; $display("FAIL single%0d_ok got %b exp %b", id, resp_ok, e.ok); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single%0d_handshake got %b exp 0", id, resp_valid); end
  endtask

  task automatic test_roundtrip_mismatch();
    bit acc; int lat; logic [127:0] lin, lkey; exp_t e;
    resp_ready = 1'b1; corrupt = 1'b1;
    sb.push_back('{id: 1'b0, ct: C0, ok: !RT});
    do_txn(1'b0, P0, K0, acc, lat, lin, lkey);
    e = sb.pop_front();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rtfail_valid got %b exp 1", resp_valid); end
    checks++; if (resp_ok !== e.ok) begin errors++; $display("FAIL rtfail_ok got %b exp %b", resp_ok, e.ok); end
    checks++; if (resp_ct !== e.ct) begin errors++; $display("FAIL rtfail_ct got %h exp %h", resp_ct, e.ct); end
    @(posedge clk); #1;
    corrupt = 1'b0;
  endtask

  task automatic test_backpressure();
    bit acc; int lat; logic [127:0] lin, lkey; exp_t e; int bad;
    resp_ready = 1'b0;
    sb.push_back('{id: 1'b1, ct: C1, ok: 1'b1});
    do_txn(1'b1, P1, K1, acc, lat, lin, lkey);
    e = sb.pop_front();
    checks++; if (resp_ct !== e.ct || resp_id !== e.id) begin errors++; $display("FAIL bp_data got %h/%b exp %h/%b", resp_ct, resp_id, e.ct, e.id); end
    req0_valid = 1'b1; req0_in = P0; req0_key = K0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_ct !== e.ct || resp_id !== e.id || resp_ok !== e.ok ||
          core_rst !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold unstable_cycles got %0d exp 0", bad); end
    @(posedge clk); #1; resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", resp_valid); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b exp 1", req0_ready); end
    req0_valid = 1'b0;
  endtask

  task automatic test_contention();
    exp_t e; bit g; bit got;
    rst = 1'b1; #3; rst = 1'b0;
    sb.delete();
    resp_ready = 1'b1; ready_viol = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_in = P0; req0_key = K0;
    req1_valid = 1'b1; req1_in = P1; req1_key = K1;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin got = 1'b1; break; end
      end
      g = req1_ready;
      checks++; if (got !== 1'b1 || g !== n[0]) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", n, g, n[0]); end
      sb.push_back('{id: g, ct: g ? C1 : C0, ok: 1'b1});
      @(posedge clk); #1;
      if (n == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      for (int i = 0; i < 200; i++) begin
        if (resp_valid) break;
        @(posedge clk); #1;
      end
      e = sb.pop_front();
      checks++; if (resp_valid !== 1'b1 || resp_id !== e.id || resp_ct !== e.ct) begin
        errors++; $display("FAIL cont_resp%0d got v=%b id=%b ct=%h exp v=1 id=%b ct=%h", n, resp_valid, resp_id, resp_ct, e.id, e.ct);
      end
    end
    @(posedge clk); #1;
    checks++; if (ready_viol !== 0) begin errors++; $display("FAIL cont_ready_outside_idle got %0d exp 0", ready_viol); end
  endtask

  task automatic test_reset_mid_run();
    bit acc; int lat; logic [127:0] lin, lkey; exp_t e; int spurious;
    resp_ready = 1'b1;
    sb.push_back('{id: 1'b0, ct: C0, ok: 1'b1});
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_in = P0; req0_key = K0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (req0_ready) break; end
    @(posedge clk); #1; req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++; if (core_state !== 6'd5 || core_rst !== 1'b0) begin errors++; $display("FAIL midrun_pre got st=%0d crst=%b exp st=5 crst=0", core_state, core_rst); end
    rst = 1'b1; #1;
    checks++; if (resp_valid !== 1'b0 || core_rst !== 1'b1) begin errors++; $display("FAIL midrun_async got v=%b crst=%b exp v=0 crst=1", resp_valid, core_rst); end
    checks++; if (core_in !== '0 || core_key !== '0 || resp_ct !== '0) begin errors++; $display("FAIL midrun_clear got %h/%h/%h exp 0", core_in, core_key, resp_ct); end
    sb.delete();
    @(posedge clk); #1; rst = 1'b0;
    spurious = 0;
    repeat (30) begin @(negedge clk); if (resp_valid !== 1'b0) spurious++; end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL midrun_discard got %0d exp 0", spurious); end
    sb.push_back('{id: 1'b1, ct: C1, ok: 1'b1});
    do_txn(1'b1, P1, K1, acc, lat, lin, lkey);
    e = sb.pop_front();
    checks++; if (lat !== EXP_EDGES) begin errors++; $display("FAIL midrun_post_latency got %0d exp %0d", lat, EXP_EDGES); end
    checks++; if (resp_ct !== e.ct || resp_id !== e.id || resp_ok !== e.ok) begin
      errors++; $display("FAIL midrun_post_data got %h/%b/%b exp %h/%b/%b", resp_ct, resp_id, resp_ok, e.ct, e.id, e.ok);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single(1'b0, P0, K0, C0);
    test_single(1'b1, P1, K1, C1);
    test_roundtrip_mismatch();
    test_backpressure();
    test_contention();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
